serial_subtractor: RTL



---
 rtl/arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: the serial engine state encoding and default operand width.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - z, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic diff,
  output logic borrow
);

  assign diff   = x ^ y ^ z;
  assign borrow = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first, one bit per clock, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  sub_state_t       state_reg;
  sub_state_t       state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-2:0] r_sh_reg;
  logic             borrow_reg;
  logic [WIDTH-1:0] r_next;
  logic             cell_diff;
  logic             cell_borrow;
  logic             accept;
  logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_reg;
  logic             b_msb_reg;
`endif

  // A start is taken in IDLE and also in DONE, which gives back-to-back operation.
  assign accept   = start && (state_reg != RUN);
  assign last_bit = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));

  full_subtractor u_cell (
    .x      (a_sh_reg[0]),
    .y      (b_sh_reg[0]),
    .z      (borrow_reg),
    .diff   (cell_diff),
    .borrow (cell_borrow)
  );

  // New diff bit enters at the MSB; after the last bit r_next holds the full difference.
  assign r_next = {cell_diff, r_sh_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      r_sh_reg   <= '0;
      borrow_reg <= 1'b0;
      d          <= '0;
      bout       <= 1'b0;
    end else if (accept) begin
      cnt_reg    <= '0;
      a_sh_reg   <= a;
      b_sh_reg   <= b;
      r_sh_reg   <= '0;
      borrow_reg <= bin;
      d          <= '0;
      bout       <= 1'b0;
    end else if (state_reg == RUN) begin
      cnt_reg    <= cnt_reg + CW'(1);
      a_sh_reg   <= a_sh_reg >> 1;
      b_sh_reg   <= b_sh_reg >> 1;
      r_sh_reg   <= r_next[WIDTH-1:1];
      borrow_reg <= cell_borrow;
      if (last_bit) begin
        d    <= r_next;
        bout <= cell_borrow;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // The operand shift registers lose their MSBs, so the sign bits are kept aside.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
      ovf       <= 1'b0;
    end else if (last_bit) begin
      ovf <= (a_msb_reg ^ b_msb_reg) & (cell_diff ^ a_msb_reg);
    end
  end
`endif

endmodule
